// File: rtl/atari_keyboard_matrix.sv
// Keyboard matrix emulation for the POKEY scanner: a host key-event stream
// becomes a 64-key pressed map with minimum-hold releases, plus modifier lines.
module atari_keyboard_matrix #(
   parameter int unsigned HOLD_SCANS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic [5:0] keyboard_scan,
   output logic [1:0] keyboard_response,
   input  logic       evt_valid,
   output logic       evt_ready,
   input  logic [1:0] evt_kind,
   input  logic [5:0] evt_code,
   input  logic       evt_press,
   input  logic       all_release,
   output logic [6:0] key_count
);

   localparam int unsigned NKEYS  = 64;
   localparam logic [1:0]  HOLD   = 2'(HOLD_SCANS);
   localparam logic [1:0]  K_KEY  = 2'b00;
   localparam logic [1:0]  K_SHF  = 2'b01;
   localparam logic [1:0]  K_CTL  = 2'b10;

   logic [NKEYS-1:0]      pressed_q, pressed_d;
   logic [NKEYS-1:0]      pending_q, pending_d;
   logic [NKEYS-1:0][1:0] seen_q, seen_d;
   logic                  shift_q, shift_d;
   logic                  control_q, control_d;
   logic                  brk_q, brk_d;
   logic [5:0]            prev_code_q, prev_code_d;
   logic [6:0]            count_q, count_d;

   logic [5:0] code;
   logic       visit;
   logic       evt_accept;

   assign code       = ~keyboard_scan;
   assign visit      = ce && (code != prev_code_q);
   assign evt_ready  = ~(reset | all_release);
   assign evt_accept = ce & evt_valid & evt_ready;
   assign key_count  = count_q;

   // Zero-latency answer to the scanner's current address.
   always_comb begin
      keyboard_response[0] = ~pressed_q[code];
      unique case (code)
         6'h00:   keyboard_response[1] = ~control_q;
         6'h10:   keyboard_response[1] = ~shift_q;
         6'h30:   keyboard_response[1] = ~brk_q;
         default: keyboard_response[1] = 1'b1;
      endcase
   end

   always_comb begin
      pressed_d   = pressed_q;
      pending_d   = pending_q;
      seen_d      = seen_q;
      shift_d     = shift_q;
      control_d   = control_q;
      brk_d       = brk_q;
      prev_code_d = prev_code_q;
      count_d     = count_q;
      if (ce) begin
         prev_code_d = code;
         if (all_release) begin
            pressed_d = '0;
            pending_d = '0;
            seen_d    = '0;
            shift_d   = 1'b0;
            control_d = 1'b0;
            brk_d     = 1'b0;
         end else begin
            // Deferred releases complete once enough scanner visits were seen.
            for (int unsigned k = 0; k < NKEYS; k++) begin
               if (pending_q[k] && (seen_q[k] >= HOLD)) begin
                  pressed_d[k] = 1'b0;
                  pending_d[k] = 1'b0;
                  seen_d[k]    = 2'b00;
               end else if (visit && (code == 6'(k)) && pressed_q[k] && (seen_q[k] < HOLD)) begin
                  seen_d[k] = seen_q[k] + 2'd1;
               end
            end
            if (evt_accept) begin
               unique case (evt_kind)
                  K_KEY: begin
                     if (evt_press) begin
                        if (!pressed_d[evt_code]) seen_d[evt_code] = 2'b00;
                        pressed_d[evt_code] = 1'b1;
                        pending_d[evt_code] = 1'b0;
                     end else if (pressed_d[evt_code]) begin
                        pending_d[evt_code] = 1'b1;
                     end
                  end
                  K_SHF:   shift_d   = evt_press;
                  K_CTL:   control_d = evt_press;
                  default: brk_d     = evt_press;
               endcase
            end
         end
         count_d = '0;
         for (int unsigned k = 0; k < NKEYS; k++) begin
            count_d = count_d + 7'(pressed_d[k]);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pressed_q   <= '0;
         pending_q   <= '0;
         seen_q      <= '0;
         shift_q     <= 1'b0;
         control_q   <= 1'b0;
         brk_q       <= 1'b0;
         prev_code_q <= '0;
         count_q     <= '0;
      end else begin
         pressed_q   <= pressed_d;
         pending_q   <= pending_d;
         seen_q      <= seen_d;
         shift_q     <= shift_d;
         control_q   <= control_d;
         brk_q       <= brk_d;
         prev_code_q <= prev_code_d;
         count_q     <= count_d;
      end
   end

endmodule

// File: tb/tb_atari_keyboard_matrix.sv
// Directed bench for atari_keyboard_matrix with HOLD_SCANS=2.
module tb_atari_keyboard_matrix;

   logic       clk = 1'b0;
   logic       reset;
   logic       ce;
   logic [5:0] keyboard_scan;
   logic [1:0] keyboard_response;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_kind;
   logic [5:0] evt_code;
   logic       evt_press;
   logic       all_release;
   logic [6:0] key_count;

   int checks = 0;
   int errors = 0;

   atari_keyboard_matrix #(.HOLD_SCANS(2)) dut (
      .clk(clk), .reset(reset), .ce(ce), .keyboard_scan(keyboard_scan),
      .keyboard_response(keyboard_response), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_kind(evt_kind), .evt_code(evt_code),
      .evt_press(evt_press), .all_release(all_release), .key_count(key_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_evt(input logic [1:0] kind, input logic [5:0] kcode, input logic press);
      evt_valid = 1'b1; evt_kind = kind; evt_code = kcode; evt_press = press;
      step();
      evt_valid = 1'b0;
   endtask

   task automatic scan(input logic [5:0] c);
      keyboard_scan = ~c;
      #1;
   endtask

   task automatic clear_all();
      all_release = 1'b1;
      step();
      all_release = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (key_count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", key_count); end
      checks++; if (evt_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", evt_ready); end
      for (int s = 0; s < 64; s += 16) begin
         scan(6'(s));
         checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL reset_resp code %0h got %b exp 11", s, keyboard_response); end
      end
      step();
      reset = 1'b0;
      scan(6'h3A);
      step();
      checks++; if (evt_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", evt_ready); end
   endtask

   task automatic test_basic();
      send_evt(2'b00, 6'h25, 1'b1);
      scan(6'h25);
      checks++; if (keyboard_response !== 2'b10) begin errors++; $display("FAIL basic_hit got %b exp 10", keyboard_response); end
      scan(6'h24);
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL basic_miss got %b exp 11", keyboard_response); end
      checks++; if (key_count !== 7'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", key_count); end
      clear_all();
   endtask

   task automatic test_ce();
      ce = 1'b0;
      send_evt(2'b00, 6'h11, 1'b1);
      ce = 1'b1;
      scan(6'h11);
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL ce_resp got %b exp 11", keyboard_response); end
      checks++; if (key_count !== 7'd0) begin errors++; $display("FAIL ce_count got %0d exp 0", key_count); end
      scan(6'h3A);
      step();
   endtask

   task automatic test_hold();
      send_evt(2'b00, 6'h0C, 1'b1);
      send_evt(2'b00, 6'h0C, 1'b0);
      checks++; if (key_count !== 7'd1) begin errors++; $display("FAIL hold_count0 got %0d exp 1", key_count); end
      scan(6'h0C);
      step(); step(); step();
      checks++; if (keyboard_response !== 2'b10) begin errors++; $display("FAIL hold_after_v1 got %b exp 10", keyboard_response); end
      scan(6'h0D);
      step();
      scan(6'h0C);
      step();
      checks++; if (keyboard_response !== 2'b10) begin errors++; $display("FAIL hold_after_v2 got %b exp 10", keyboard_response); end
      checks++; if (key_count !== 7'd1) begin errors++; $display("FAIL hold_count1 got %0d exp 1", key_count); end
      step();
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL hold_released got %b exp 11", keyboard_response); end
      checks++; if (key_count !== 7'd0) begin errors++; $display("FAIL hold_count2 got %0d exp 0", key_count); end
      scan(6'h3A);
      step();
   endtask

   task automatic test_modifiers();
      send_evt(2'b01, 6'h00, 1'b1);
      scan(6'h10);
      checks++; if (keyboard_response !== 2'b01) begin errors++; $display("FAIL shift_at10 got %b exp 01", keyboard_response); end
      scan(6'h00);
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL shift_at00 got %b exp 11", keyboard_response); end
      scan(6'h30);
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL shift_at30 got %b exp 11", keyboard_response); end
      send_evt(2'b10, 6'h00, 1'b1);
      scan(6'h00);
      checks++; if (keyboard_response !== 2'b01) begin errors++; $display("FAIL ctrl_at00 got %b exp 01", keyboard_response); end
      send_evt(2'b11, 6'h00, 1'b1);
      scan(6'h30);
      checks++; if (keyboard_response !== 2'b01) begin errors++; $display("FAIL brk_at30 got %b exp 01", keyboard_response); end
      scan(6'h20);
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL mod_at20 got %b exp 11", keyboard_response); end
      send_evt(2'b01, 6'h00, 1'b0);
      scan(6'h10);
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL shift_rel got %b exp 11", keyboard_response); end
      send_evt(2'b10, 6'h00, 1'b0);
      send_evt(2'b11, 6'h00, 1'b0);
      scan(6'h00);
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL ctrl_rel got %b exp 11", keyboard_response); end
      scan(6'h30);
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL brk_rel got %b exp 11", keyboard_response); end
      checks++; if (key_count !== 7'd0) begin errors++; $display("FAIL mod_count got %0d exp 0", key_count); end
      scan(6'h20);
      step();
   endtask

   task automatic test_repress();
      send_evt(2'b00, 6'h3F, 1'b1);
      send_evt(2'b00, 6'h3F, 1'b0);
      scan(6'h3F);
      step();
      scan(6'h20);
      step();
      send_evt(2'b00, 6'h3F, 1'b1);
      step(); step();
      checks++; if (key_count !== 7'd1) begin errors++; $display("FAIL repress_count got %0d exp 1", key_count); end
      scan(6'h3F);
      checks++; if (keyboard_response !== 2'b10) begin errors++; $display("FAIL repress_held got %b exp 10", keyboard_response); end
      scan(6'h20);
      send_evt(2'b00, 6'h3F, 1'b0);
      scan(6'h3F);
      step();
      step();
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL repress_seen_kept got %b exp 11", keyboard_response); end
      checks++; if (key_count !== 7'd0) begin errors++; $display("FAIL repress_final got %0d exp 0", key_count); end
      scan(6'h20);
      step();
   endtask

   task automatic test_all_release();
      send_evt(2'b01, 6'h00, 1'b1);
      for (int k = 0; k < 64; k++) send_evt(2'b00, 6'(k), 1'b1);
      checks++; if (key_count !== 7'd64) begin errors++; $display("FAIL full_count got %0d exp 64", key_count); end
      all_release = 1'b1;
      evt_valid = 1'b1; evt_kind = 2'b00; evt_code = 6'h05; evt_press = 1'b1;
      #1;
      checks++; if (evt_ready !== 1'b0) begin errors++; $display("FAIL allrel_ready got %b exp 0", evt_ready); end
      step();
      all_release = 1'b0; evt_valid = 1'b0;
      checks++; if (key_count !== 7'd0) begin errors++; $display("FAIL allrel_count got %0d exp 0", key_count); end
      for (int s = 0; s < 64; s++) begin
         scan(6'(s));
         checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL allrel_resp code %0h got %b exp 11", s, keyboard_response); end
      end
      scan(6'h3A);
      step();
   endtask

   task automatic test_reset_mid();
      send_evt(2'b01, 6'h00, 1'b1);
      send_evt(2'b00, 6'h0C, 1'b1);
      send_evt(2'b00, 6'h0C, 1'b0);
      scan(6'h0C);
      step();
      #2 reset = 1'b1;
      #1;
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL rstmid_resp got %b exp 11", keyboard_response); end
      checks++; if (key_count !== 7'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", key_count); end
      checks++; if (evt_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b exp 0", evt_ready); end
      scan(6'h10);
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL rstmid_shift got %b exp 11", keyboard_response); end
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         scan(6'h0C); step();
         scan(6'h0D); step();
      end
      scan(6'h0C);
      checks++; if (keyboard_response !== 2'b11) begin errors++; $display("FAIL rstmid_after got %b exp 11", keyboard_response); end
      checks++; if (key_count !== 7'd0) begin errors++; $display("FAIL rstmid_after_count got %0d exp 0", key_count); end
   endtask

   initial begin
      reset = 1'b1; ce = 1'b1; keyboard_scan = ~6'h3A;
      evt_valid = 1'b0; evt_kind = 2'b00; evt_code = 6'h00; evt_press = 1'b0;
      all_release = 1'b0;
      test_reset();
      test_basic();
      test_ce();
      test_hold();
      test_modifiers();
      test_repress();
      test_all_release();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
